// File: rtl/game_cmd_sequencer.sv
// Command sequencer for the game counter: buffers commands in a small FIFO,
// replays them onto control/INIT_c/INIT_l, and handles the game-over clear/hold cycle.
module game_cmd_sequencer #(
  parameter int SIZE        = 4,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic                     cmd_load,
  input  logic [SIZE-1:0]          cmd_value,
  input  logic [3:0]               cmd_repeat,
  output logic [1:0]               control,
  output logic                     INIT_c,
  output logic [SIZE-1:0]          INIT_l,
  input  logic                     GAMEOVER,
  output logic                     clr_reset,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_END} state_t;

  typedef struct packed {
    logic [1:0]      op;
    logic            load;
    logic [SIZE-1:0] value;
    logic [3:0]      rep;
  } cmd_t;

  cmd_t            mem [DEPTH];
  cmd_t            head;
  cmd_t            incoming;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            flush;

  state_t          state;
  state_t          state_n;
  logic [3:0]      remaining;
  logic [3:0]      remaining_n;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_n;
  logic [1:0]      control_n;
  logic            init_c_n;
  logic [SIZE-1:0] init_l_n;
  logic            clr_n;

  assign empty      = (level == '0);
  assign full       = (level == LW'(DEPTH));
  assign cmd_ready  = !full && (state != ST_END);
  assign push       = cmd_valid && cmd_ready && !flush;
  assign busy       = (state != ST_IDLE);
  assign fifo_level = level;
  assign head       = mem[rd_ptr];
  assign incoming   = {cmd_op, cmd_load, cmd_value, cmd_repeat};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= incoming;
    end
  end

  // A game-over flush also discards a command offered in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      hold_cnt  <= '0;
      control   <= '0;
      INIT_c    <= 1'b0;
      INIT_l    <= '0;
      clr_reset <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      hold_cnt  <= hold_n;
      control   <= control_n;
      INIT_c    <= init_c_n;
      INIT_l    <= init_l_n;
      clr_reset <= clr_n;
    end
  end

  // Outputs are computed one cycle ahead so they line up with the state they belong to.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    hold_n      = hold_cnt;
    control_n   = control;
    init_c_n    = 1'b0;
    init_l_n    = INIT_l;
    clr_n       = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;

    if (state != ST_END && GAMEOVER) begin
      state_n   = ST_END;
      flush     = 1'b1;
      clr_n     = 1'b1;
      control_n = '0;
      hold_n    = '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_RUN: begin
          if (state == ST_IDLE || remaining == '0) begin
            if (!empty) begin
              pop         = 1'b1;
              remaining_n = head.rep;
              control_n   = head.op;
              if (head.load) begin
                state_n  = ST_LOAD;
                init_c_n = 1'b1;
                init_l_n = head.value;
              end else begin
                state_n = ST_RUN;
              end
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            remaining_n = remaining - 4'd1;
          end
        end
        ST_LOAD: state_n = ST_RUN;
        ST_END: begin
          if (hold_cnt == HW'(HOLD_CYCLES)) state_n = ST_IDLE;
          else                               hold_n  = hold_cnt + HW'(1);
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule
